// File: rtl/sparhixcel_pkg.sv
// Shared defaults for the weight path (array geometry, memory width) and the
// weight_prefetch_buffer control state encoding.
package sparhixcel_pkg;

  localparam int DEF_N_ROWS_ARRAY = 16;
  localparam int DEF_F_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_CNT_WIDTH    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wpb_state_t;

endpackage

// File: rtl/weight_fifo2.sv
// Two-entry ping-pong FIFO holding prefetched weight vectors; the head output
// keeps the last popped vector once the FIFO runs empty.
module weight_fifo2 #(
  parameter int W = 128
) (
  input  logic         clk_i,
  input  logic         rd_weight_rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [W-1:0]      last_q;
  logic              pop_ok;

  // Pops on an empty FIFO are dropped so the count can never underflow.
  assign pop_ok = pop && (count != 2'd0);
  assign dout   = (count != 2'd0) ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      last_q <= '0;
    end else begin
      // When full, push lands on the head slot; a same-edge pop has already
      // consumed that entry, so the overwrite is safe.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
        last_q <= mem[rd_ptr];
      end
      count <= count + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rd_weight_rst)
    !(push && (count == 2'd2) && !pop));

endmodule

// File: rtl/weight_prefetch_buffer.sv
// Prefetches weight-memory rows into a 2-entry buffer and streams them to the
// systolic-array weight register as a valid/ready vector stream.
module weight_prefetch_buffer
  import sparhixcel_pkg::*;
#(
  parameter int N_ROWS_ARRAY = DEF_N_ROWS_ARRAY,
  parameter int F_WIDTH      = DEF_F_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rd_weight_rst,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0]           num_words_i,
  input  logic                           weight_ready_i,
  output logic                           mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic [N_ROWS_ARRAY*F_WIDTH-1:0] mem_data_i,
  input  logic                           weight_req_i,
  output logic                           weight_valid_o,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0] f_weight_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int VEC_W = N_ROWS_ARRAY * F_WIDTH;

  wpb_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  issued_nxt;
  logic                  inflight_q;
  logic [1:0]            occ;
  logic                  pop;
  logic                  issue;
  logic [2:0]            room_sum;

  assign pop            = weight_req_i && weight_valid_o;
  assign weight_valid_o = (occ != 2'd0);

  // Slots committed after this edge: buffered + in flight - leaving now.
  // pop implies occ>=1, so the subtraction cannot go negative.
  assign room_sum   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state == FETCH) && weight_ready_i && (room_sum < 3'd2);
  assign issued_nxt = issued_q + CNT_WIDTH'(1);

  assign mem_rd_en_o = issue;
  assign mem_addr_o  = base_q + ADDR_WIDTH'(issued_q);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = (num_words_i == '0) ? DONE : FETCH;
      // Leave FETCH on the edge of the last issue so no extra read can slip out.
      FETCH: if (issue && (issued_nxt == num_q)) state_nxt = DRAIN;
      DRAIN: if ((occ == 2'd0) && !inflight_q) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state      <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight_q <= issue;
      if ((state == IDLE) && start_i) begin
        base_q   <= base_addr_i;
        num_q    <= num_words_i;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_nxt;
      end
    end
  end

  // Memory returns data one cycle after the strobe, which is exactly when the
  // inflight flag is set.
  weight_fifo2 #(.W(VEC_W)) u_fifo (
    .clk_i         (clk_i),
    .rd_weight_rst (rd_weight_rst),
    .push          (inflight_q),
    .pop           (pop),
    .din           (mem_data_i),
    .dout          (f_weight_o),
    .count         (occ)
  );

endmodule

// File: tb/tb_weight_prefetch_buffer.sv
// Randomized scoreboard bench for weight_prefetch_buffer: stimulus pushes the
// expected address/vector stream, a negedge monitor pops and compares.
module tb_weight_prefetch_buffer;

  localparam int NR = 16, FW = 8, AW = 16, CW = 10, VW = NR * FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          weight_ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_data = '0;
  logic          weight_req = 1'b0;
  logic          weight_valid;
  logic [VW-1:0] f_weight;
  logic          busy;
  logic          done;

  weight_prefetch_buffer #(.N_ROWS_ARRAY(NR), .F_WIDTH(FW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rd_weight_rst(rst), .start_i(start), .base_addr_i(base_addr),
    .num_words_i(num_words), .weight_ready_i(weight_ready), .mem_rd_en_o(mem_rd_en),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data), .weight_req_i(weight_req),
    .weight_valid_o(weight_valid), .f_weight_o(f_weight), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, iss_cnt = 0, done_cnt = 0, out_cnt = 0;
  logic [31:0] seed = 32'h1234_5678;
  logic [VW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  function automatic logic [VW-1:0] mem_fn(input logic [AW-1:0] a, input logic [31:0] s);
    logic [31:0] h;
    h = {16'h0, a} * 32'd2654435761;
    return {s, a, ~a, s ^ {a, ~a}, h};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Weight memory: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_data <= mem_fn(mem_addr, seed);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (weight_valid && weight_req) begin
        out_cnt--;
        if (exp_q.size() == 0) chk("extra_vec", 1, 0);
        else chk("vec", f_weight, exp_q.pop_front());
      end
      if (mem_rd_en) begin
        chk("rd_while_notready", weight_ready, 1);
        if (addr_q.size() == 0) chk("extra_read", 1, 0);
        else chk("addr", mem_addr, addr_q.pop_front());
        iss_cnt++;
        out_cnt++;
        chk("room", out_cnt <= 2, 1);
      end
      if (done) begin
        done_cnt++;
        chk("done_vec_left", exp_q.size(), 0);
        chk("done_addr_left", addr_q.size(), 0);
      end
    end
  end

  task automatic run_xfer(input logic [AW-1:0] base, input int n, input int req_p, input int rdy_p,
                          input int req_hold, input bit rdy_gap, input int poke_k,
                          input int exp_v, input int exp_d);
    int k, c0, iss0, done0, gap;
    bit seen_v, seen_d, gap_done;
    k = 0; gap = 0; seen_v = 0; seen_d = 0; gap_done = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem_fn(base + AW'(i), seed));
      addr_q.push_back(base + AW'(i));
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = CW'(n); weight_ready = 1'b1;
    iss0 = iss_cnt; done0 = done_cnt;
    @(posedge clk); #1;
    c0 = cyc;
    while (!seen_d && k < 600) begin
      if (req_hold == 10 && k == 10) chk("stall_reads", iss_cnt - iss0, 2);
      if (rdy_gap && !gap_done && (iss_cnt - iss0) >= 2) begin
        gap = 3; gap_done = 1;
      end
      weight_req = (k < req_hold) ? 1'b0 : ($urandom_range(99) < req_p);
      if (gap > 0) begin
        weight_ready = 1'b0; gap--;
      end else weight_ready = ($urandom_range(99) < rdy_p);
      start = (k == poke_k);
      base_addr = ~base; num_words = 3;
      @(negedge clk);
      if (req_hold == 10 && k == 9) chk("stall_rden", mem_rd_en, 0);
      if (weight_valid && !seen_v) begin
        seen_v = 1;
        if (exp_v >= 0) chk("vld_lat", cyc - c0, exp_v);
      end
      if (done) begin
        seen_d = 1;
        if (exp_d >= 0) chk("done_lat", cyc - c0, exp_d);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; weight_req = 1'b0;
    if (!seen_d) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse_len", done, 0);
    chk("idle_after_done", busy, 0);
    #1 chk("done_count", done_cnt - done0, 1);
    if (!seen_d) begin
      exp_q.delete(); addr_q.delete();
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_valid", weight_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fw", f_weight, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Full-rate transfer: valid 2 cycles after start, done 7 cycles after.
    run_xfer(16'h0010, 4, 100, 100, 0, 0, -1, 2, 7);
    // Minimum transfer.
    seed = $urandom;
    run_xfer(16'h0100, 1, 100, 100, 0, 0, -1, 2, 4);
    // Consumer stalls 10 cycles; start poke mid-transfer must be ignored.
    seed = $urandom;
    run_xfer(16'h0200, 6, 100, 100, 10, 0, 3, -1, -1);
    // Memory not ready for 3 cycles after the 2nd issue.
    seed = $urandom;
    run_xfer(16'h0300, 5, 100, 100, 0, 1, -1, -1, -1);
    // Address wrap at the top of memory.
    seed = $urandom;
    run_xfer(16'hFFFE, 4, 100, 100, 0, 0, -1, -1, -1);
    // Empty transfer; a start during DONE is ignored.
    run_xfer(16'h0400, 0, 100, 100, 0, 0, 0, -1, 0);

    // Abort: reset with two vectors buffered.
    seed = $urandom;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mem_fn(16'h0500 + AW'(i), seed));
      addr_q.push_back(16'h0500 + AW'(i));
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0500; num_words = 8; weight_ready = 1'b1; weight_req = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("abort_full", weight_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_valid", weight_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_fw", f_weight, 0);
    exp_q.delete(); addr_q.delete(); out_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1 chk("abort_no_done", done_cnt - d0, 0);
    end
    seed = $urandom;
    run_xfer(16'h0600, 3, 100, 100, 0, 0, -1, 2, -1);

    // Random transfers with random consumer/memory backpressure.
    for (int t = 0; t < 20; t++) begin
      seed = $urandom;
      run_xfer(AW'($urandom_range(65535)), $urandom_range(1, 12), $urandom_range(30, 100),
               $urandom_range(40, 100), 0, 0, (t % 4 == 0) ? 2 : -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
